// File: rtl/spu_pkg.sv
// Shared SPU types and constants for the register-fetch slice.
package spu_pkg;

  localparam int NUM_REGS = 128;
  localparam int ADDR_W   = 7;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [127:0]      qword_t;
  typedef logic [10:0]       opcode_t;
  typedef logic [17:0]       imm_t;
  typedef logic [2:0]        fmt_t;

  localparam fmt_t FMT_RR   = 3'd0;
  localparam fmt_t FMT_RI10 = 3'd4;
  localparam fmt_t FMT_RI16 = 3'd5;

  // Decoded control fields carried through the fetch pipeline register.
  typedef struct packed {
    opcode_t   op;
    fmt_t      fmt;
    reg_addr_t dest;
    imm_t      imm;
    logic      wen;
  } ctrl_t;

endpackage

// File: rtl/spu_regfile.sv
// SPU register file: one synchronous write port, three combinational read ports.
// A synchronous reset clears every entry and overrides a concurrent write.
module spu_regfile
  import spu_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  reg_addr_t         waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_addr_t         ra_addr,
  input  reg_addr_t         rb_addr,
  input  reg_addr_t         rt_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (we) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign ra_data = rf_q[ra_addr];
  assign rb_data = rf_q[rb_addr];
  assign rt_data = rf_q[rt_addr];

endmodule

// File: rtl/reg_fetch_forward.sv
// Register fetch with operand bypass and a one-cycle output register.
// Define RF_FORWARDING_EN to enable bypass from the delayed result slots.
module reg_fetch_forward
  import spu_pkg::*;
#(
  parameter int NUM_REGS  = 128,
  parameter int DATA_W    = 128,
  parameter int FWD_DEPTH = 6
) (
  input  logic                             clock,
  input  logic                             reset,
  input  opcode_t                          in_op_code,
  input  fmt_t                             in_instr_format,
  input  reg_addr_t                        in_dest_reg_addr,
  input  reg_addr_t                        in_ra_addr,
  input  reg_addr_t                        in_rb_addr,
  input  reg_addr_t                        in_rt_addr,
  input  imm_t                             in_imm_value,
  input  logic                             in_enable_reg_write,
  input  logic [DATA_W-1:0]                wb_data,
  input  reg_addr_t                        wb_reg_addr,
  input  logic                             wb_enable_reg_write,
  input  logic [FWD_DEPTH-1:0][DATA_W-1:0] fwd_data,
  input  logic [FWD_DEPTH-1:0][ADDR_W-1:0] fwd_addr,
  input  logic [FWD_DEPTH-1:0]             fwd_enable,
  input  logic                             branch_is_taken,
  output opcode_t                          op_code,
  output fmt_t                             instr_format,
  output reg_addr_t                        dest_reg_addr,
  output imm_t                             imm_value,
  output logic                             enable_reg_write,
  output logic [DATA_W-1:0]                src_reg_a,
  output logic [DATA_W-1:0]                src_reg_b,
  output logic [DATA_W-1:0]                store_reg
);

  logic [DATA_W-1:0] rf_a, rf_b, rf_t;
  logic [DATA_W-1:0] opa_d, opb_d, opt_d;
  logic [DATA_W-1:0] opa_q, opb_q, opt_q;
  ctrl_t             ctrl_d, ctrl_q;

  spu_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_enable_reg_write),
    .waddr   (wb_reg_addr),
    .wdata   (wb_data),
    .ra_addr (in_ra_addr),
    .rb_addr (in_rb_addr),
    .rt_addr (in_rt_addr),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .rt_data (rf_t)
  );

  // Youngest matching source wins: fwd slot 0 first, then write-back, then rf.
  function automatic logic [DATA_W-1:0] resolve(
    input reg_addr_t                        a,
    input logic [DATA_W-1:0]                rfv,
    input logic [FWD_DEPTH-1:0][DATA_W-1:0] fd,
    input logic [FWD_DEPTH-1:0][ADDR_W-1:0] fa,
    input logic [FWD_DEPTH-1:0]             fe
  );
    logic [DATA_W-1:0] r;
    r = rfv;
    if (wb_enable_reg_write && (wb_reg_addr == a)) r = wb_data;
`ifdef RF_FORWARDING_EN
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (fe[i] && (fa[i] == a)) r = fd[i];
    end
`else
    r = r | ({DATA_W{1'b0}} & {{(DATA_W-1){1'b0}}, ^{fd, fa, fe}});
`endif
    return r;
  endfunction

  always_comb begin
    opa_d  = resolve(in_ra_addr, rf_a, fwd_data, fwd_addr, fwd_enable);
    opb_d  = resolve(in_rb_addr, rf_b, fwd_data, fwd_addr, fwd_enable);
    opt_d  = resolve(in_rt_addr, rf_t, fwd_data, fwd_addr, fwd_enable);
    ctrl_d = '{op: in_op_code, fmt: in_instr_format, dest: in_dest_reg_addr,
               imm: in_imm_value, wen: in_enable_reg_write};
  end

  // Output pipeline register; a taken branch loads the all-zero nop bubble.
  always_ff @(posedge clock) begin
    if (reset || branch_is_taken) begin
      ctrl_q <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      opt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      opt_q  <= opt_d;
    end
  end

  assign op_code          = ctrl_q.op;
  assign instr_format     = ctrl_q.fmt;
  assign dest_reg_addr    = ctrl_q.dest;
  assign imm_value        = ctrl_q.imm;
  assign enable_reg_write = ctrl_q.wen;
  assign src_reg_a        = opa_q;
  assign src_reg_b        = opb_q;
  assign store_reg        = opt_q;

endmodule

// File: doc/reg_fetch_forward.md
Name: reg_fetch_forward

Overview:
- Register-file-and-forwarding stage directly upstream of the local-store / execute stages.
- Holds the 128 x 128-bit SPU register file.
- Reads up to three source operands per cycle (ra, rb, and rt used as store data), resolving hazards by bypassing from the in-flight delayed result pipeline and the write-back port.
- Registers the decoded instruction plus resolved operands into a one-cycle pipeline register that feeds the downstream stage.

Parameters:
NUM_REGS, 128, number of architectural registers (address width 7)
DATA_W, 128, register width in bits
FWD_DEPTH, 6, number of in-flight delayed result slots offered for bypass

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_op_code  input  11  decoded opcode [0:10], truncated per format
in_instr_format  input  3  instruction format
in_dest_reg_addr  input  7  destination register [0:6]
in_ra_addr  input  7  source A register address
in_rb_addr  input  7  source B register address
in_rt_addr  input  7  store-data register address
in_imm_value  input  18  immediate [0:17]
in_enable_reg_write  input  1  instruction writes register file
wb_data  input  128  write-back value
wb_reg_addr  input  7  write-back destination
wb_enable_reg_write  input  1  write-back valid
fwd_data  input  FWD_DEPTH x 128  delayed result data, slot 0 youngest
fwd_addr  input  FWD_DEPTH x 7  delayed result destinations
fwd_enable  input  FWD_DEPTH  delayed result valid flags
branch_is_taken  input  1  flush request for the instruction entering this cycle
op_code  output  11  registered opcode
instr_format  output  3  registered format
dest_reg_addr  output  7  registered destination
imm_value  output  18  registered immediate
enable_reg_write  output  1  registered write flag
src_reg_a  output  128  resolved operand A
src_reg_b  output  128  resolved operand B
store_reg  output  128  resolved store data

Behaviour:
- Clocking and reset: one clock, `clock`. `reset` is synchronous and active-high.
- On reset, every register-file entry = 0, and every output = 0. All-zero outputs decode as a nop (format 0, opcode 0, write disabled).
- Register file write: on a clock edge with `wb_enable_reg_write=1`, `rf[wb_reg_addr] <= wb_data`. Register 0 is an ordinary writable register.
- Operand resolution is combinational, per operand. Priority, highest first:
  - `fwd` slot 0 .. `FWD_DEPTH-1`, taking the lowest index whose enable=1 and whose addr matches;
  - the write-back port, if enable=1 and the address matches;
  - `rf[addr]`.
- This gives write-through semantics: a same-cycle write-back is visible to the reader.
- Latency: exactly 1 cycle from inputs to outputs. All outputs update on every non-reset edge; there is no stall.
- Flush: if `branch_is_taken=1` at an edge, outputs load the nop bubble (all fields 0, operands 0). The register-file write on that edge still occurs.
- Nop input (format 0, opcode 0): the instruction passes through unchanged. Operands are still resolved; there is no special case.
- Reset mid-stream: reset overrides both the write-back and the flush. Any write-back arriving on a reset edge is discarded.
- Widths: all addresses compare as 7-bit unsigned. No arithmetic is performed in this block.

Optional Feature:
- Macro: `RF_FORWARDING_EN`.
- Defined: the full bypass network described above.
- Undefined:
  - `fwd_*` ports remain present but are ignored.
  - Operands resolve from the write-back port (write-through) or the register file only.
  - Downstream hazards are then software's responsibility.

Decomposition:
- Shared package `spu_pkg`:
  - typedefs `reg_addr_t` (7b), `qword_t` (128b), `opcode_t` (11b), `imm_t` (18b);
  - constants `NUM_REGS`, `FMT_RR=0`, `FMT_RI10=4`, `FMT_RI16=5`.
- One natural sub-module: `spu_regfile`.
  - 128x128 array, one synchronous write port, three combinational read ports.
  - Reset clear.
- Bypass muxing and the output pipeline register stay in `reg_fetch_forward`.

Test Plan:
1. Reset, then issue ra=5, rb=6, rt=7 with no writes -> next cycle `src_reg_a`, `src_reg_b` and `store_reg` are all 0, and all control outputs are 0.
2. wb writes r5=0xAAAA…; the following cycle issues ra=5 -> next cycle `src_reg_a`=0xAAAA….
3. Same-cycle wb r9=0x1234 with ra=9 issued -> next cycle `src_reg_a`=0x1234 (write-through).
4. `fwd` slot 3 holds r9=0x33 and slot 1 holds r9=0x11, both enabled, with rf r9=0x99 -> `src_reg_a`=0x11. With macro undefined -> `src_reg_a`=0x99.
5. Issue lqd (format 4, dest 12, write=1) with `branch_is_taken=1` and a concurrent wb to r3=0x55 -> outputs are all 0, and a later read of r3 returns 0x55.
6. Assert reset for one cycle with a concurrent wb r4=0x77 -> a later read of r4 returns 0, and the outputs are the nop bubble.
